// File: rtl/dec_lut_encoder8bits_clk.sv
// Sequential triangular-number encoder: W = N*(N+1)/2, built with one add per cycle.
// Transmit-side partner of the clocked LUT decoder; result held with a level done flag.
module dec_lut_encoder8bits_clk #(
  parameter int W_BITS = 20,
  parameter int N_BITS = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_BITS-1:0] N_in,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [W_BITS-1:0] W
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [N_BITS-1:0]   r_n;
  logic [N_BITS-1:0]   r_k;
  logic [W_BITS-1:0]   r_acc;
  logic [W_BITS-1:0]   r_w;
  logic                r_done;
  logic [W_BITS-1:0]   w_sum;
  logic                w_accept;
  logic                w_last;

  // k is zero-extended into the codeword width; the sum wraps modulo 2^W_BITS.
  assign w_sum  = r_acc + W_BITS'(r_k);
  // Comparing before the increment means k stops at n_reg and never wraps.
  assign w_last = (r_state == S_ACC) && (r_k == r_n);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    busy         = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        ready = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_ACC;
        end
      end
      S_ACC: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_n    <= '0;
      r_k    <= '0;
      r_acc  <= '0;
      r_w    <= '0;
      r_done <= 1'b0;
    end else if (w_accept) begin
      // W keeps the previous result until the new one is written.
      r_n    <= N_in;
      r_k    <= '0;
      r_acc  <= '0;
      r_done <= 1'b0;
    end else if (r_state == S_ACC) begin
      r_acc <= w_sum;
      if (w_last) begin
        r_w    <= w_sum;
        r_done <= 1'b1;
      end else begin
        r_k <= r_k + N_BITS'(1);
      end
    end
  end

  assign done = r_done;
  assign W    = r_w;

endmodule

// File: tb/tb_dec_lut_encoder8bits_clk.sv
// Directed self-checking bench for dec_lut_encoder8bits_clk: latency, codeword values,
// ignored start while busy, back-to-back requests, mid-operation reset, and a sweep.
module tb_dec_lut_encoder8bits_clk;

  localparam int W_BITS = 20;
  localparam int N_BITS = 9;
  localparam int BUDGET = 2000;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [N_BITS-1:0] N_in;
  logic              ready;
  logic              busy;
  logic              done;
  logic [W_BITS-1:0] W;

  int n_cmp  = 0;
  int n_fail = 0;

  dec_lut_encoder8bits_clk #(.W_BITS(W_BITS), .N_BITS(N_BITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .N_in  (N_in),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .W     (W)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for done to rise; returns the number of edges taken, or BUDGET+1 on timeout.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (cycles <= BUDGET) begin
      step();
      cycles++;
      if (done) return;
    end
    cycles = BUDGET + 1;
  endtask

  // Reference inverse of the encoder (what the decoder does): finds n with n(n+1)/2 == w.
  function automatic int decode(input logic [W_BITS-1:0] w);
    for (int i = 0; i < (1 << N_BITS); i++)
      if (((i * (i + 1)) / 2) == int'(w)) return i;
    return -1;
  endfunction

  task automatic encode(input int n, input string tag);
    int cyc;
    int exp_w;
    start = 1'b1;
    N_in  = N_BITS'(n);
    step();
    start = 1'b0;
    N_in  = '0;
    wait_done(cyc);
    exp_w = ((n * (n + 1)) / 2) % (1 << W_BITS);
    check({tag, ".lat"},   cyc, n + 1);
    check({tag, ".W"},     W, exp_w);
    check({tag, ".ready"}, ready, 1);
    check({tag, ".rt"},    decode(W), n);
  endtask

  initial begin
    int cyc;
    rst   = 1'b1;
    start = 1'b0;
    N_in  = '0;
    step();
    step();
    check("rst.ready", ready, 1);
    check("rst.busy",  busy, 0);
    check("rst.done",  done, 0);
    check("rst.W",     W, 0);
    rst = 1'b0;
    step();

    // Encode 255 and round-trip it
    start = 1'b1;
    N_in  = 9'd255;
    step();
    start = 1'b0;
    check("n255.busy", busy, 1);
    check("n255.ready", ready, 0);
    wait_done(cyc);
    check("n255.lat",   cyc, 256);
    check("n255.W",     W, 32640);
    check("n255.ready", ready, 1);
    check("n255.rt",    decode(W), 255);

    // Smallest and largest N
    encode(0, "n0");
    check("n0.W0", W, 0);
    encode(511, "n511");
    check("n511.W", W, 130816);

    // start while busy is ignored
    start = 1'b1;
    N_in  = 9'd10;
    step();
    start = 1'b0;
    repeat (3) step();
    start = 1'b1;
    N_in  = 9'd3;
    step();
    start = 1'b0;
    check("busy.still", busy, 1);
    wait_done(cyc);
    check("busy.lat", cyc + 4, 11);
    check("busy.W",   W, 55);
    repeat (3) step();
    check("busy.nosecond.done", done, 1);
    check("busy.nosecond.busy", busy, 0);
    check("busy.nosecond.W",    W, 55);

    // Back-to-back requests with start held high
    start = 1'b1;
    N_in  = 9'd4;
    step();
    N_in  = 9'd6;
    wait_done(cyc);
    check("b2b.lat1", cyc, 5);
    check("b2b.W1",   W, 10);
    check("b2b.rdy1", ready, 1);
    step();
    start = 1'b0;
    check("b2b.done_fall", done, 0);
    check("b2b.busy2",     busy, 1);
    check("b2b.W_hold",    W, 10);
    wait_done(cyc);
    check("b2b.lat2", cyc, 7);
    check("b2b.W2",   W, 21);

    // Reset mid-operation discards the partial sum
    start = 1'b1;
    N_in  = 9'd100;
    step();
    start = 1'b0;
    repeat (49) step();
    check("mid.busy", busy, 1);
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check("mid.done",  done, 0);
    check("mid.W",     W, 0);
    check("mid.ready", ready, 1);
    check("mid.busy0", busy, 0);
    step();
    check("mid.idle", ready, 1);
    encode(3, "mid.n3");
    check("mid.W6", W, 6);

    // Sweep: every N in 0..31, then a stride across the full range
    for (int n = 0; n < 32; n++) encode(n, "sweep.lo");
    for (int n = 32; n < 512; n += 29) encode(n, "sweep.hi");
    encode(510, "sweep.510");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
